// File: rtl/pcode_decoder_seq.sv
// Sequential priority-code decoder: buffers 3-bit codes in a small FIFO and
// replays each as a one-hot x[4:1] vector held for HOLD cycles.
module pcode_decoder_seq #(
  parameter int DEPTH = 4,
  parameter int HOLD  = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [2:0]                 pcode,
  input  logic                       pcode_valid,
  output logic                       pcode_ready,
  output logic [4:1]                 x,
  output logic                       x_valid,
  output logic                       err,
  output logic                       busy,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = PTR_W + 1;
  localparam int CNT_W = (HOLD > 1) ? $clog2(HOLD) : 1;

  typedef enum logic {S_IDLE, S_HOLD} state_t;

  function automatic logic [4:1] decode(input logic [2:0] c);
    logic [4:1] v;
    case (c)
      3'b100:  v = 4'b1000;
      3'b011:  v = 4'b0100;
      3'b010:  v = 4'b0010;
      3'b001:  v = 4'b0001;
      default: v = 4'b0000;
    endcase
    return v;
  endfunction

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic [4:1]         x_q, x_d;
  logic               x_valid_q, x_valid_d;
  logic               err_q, err_d;
  logic               busy_q, busy_d;
  logic [2:0]         fifo_mem [DEPTH];

  logic accept, code_bad, push, pop, fifo_empty;

  assign pcode_ready = (count_q < CW'(DEPTH));
  assign fifo_empty  = (count_q == '0);
  assign accept      = pcode_valid && pcode_ready;
  assign code_bad    = (pcode > 3'b100);
  // Invalid codes complete the handshake but never enter the FIFO.
  assign push        = accept && !code_bad;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    x_d       = x_q;
    x_valid_d = x_valid_q;
    pop       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          x_d       = decode(fifo_mem[rd_ptr_q]);
          x_valid_d = 1'b1;
          cnt_d     = CNT_W'(HOLD - 1);
          state_d   = S_HOLD;
        end else begin
          x_d       = '0;
          x_valid_d = 1'b0;
        end
      end
      S_HOLD: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (!fifo_empty) begin
          // Chain straight into the next code so x_valid never drops.
          pop   = 1'b1;
          x_d   = decode(fifo_mem[rd_ptr_q]);
          cnt_d = CNT_W'(HOLD - 1);
        end else begin
          x_d       = '0;
          x_valid_d = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
    err_d    = accept && code_bad;
    busy_d   = (state_d == S_HOLD) || (count_d != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      x_q       <= '0;
      x_valid_q <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      x_q       <= x_d;
      x_valid_q <= x_valid_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= pcode;
  end

  assign x       = x_q;
  assign x_valid = x_valid_q;
  assign err     = err_q;
  assign busy    = busy_q;
  assign count   = count_q;

endmodule

// File: doc/pcode_decoder_seq.md
# pcode_decoder_seq

Sequential decoder for the 3-bit priority code produced by the team's 4-input priority encoder. It accepts codes over a valid/ready handshake, buffers them in a small FIFO, and replays each one as a one-hot request vector `x[4:1]`, held for a programmable number of cycles. It sits on the receiving side of any link that carries encoded priority requests and regenerates the original request lines for downstream logic.

## Interface
- `DEPTH`, 4: FIFO depth in codes; power of 2, ≥ 2.
- `HOLD`, 3: cycles each decoded vector is presented; ≥ 1.

- `clk` in 1: single clock; all state is updated on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `pcode` in 3: encoded priority code.
- `pcode_valid` in 1: `pcode` is valid this cycle.
- `pcode_ready` out 1: block can accept a code; equals `count < DEPTH`.
- `x` out 4 [4:1]: decoded one-hot request vector.
- `x_valid` out 1: `x` is being presented.
- `err` out 1: one-cycle pulse; an invalid code was accepted.
- `busy` out 1: high when the FSM is in HOLD or `count != 0`.
- `count` out $clog2(DEPTH)+1: number of codes currently in the FIFO.

## Operation
- Accept: a transfer completes on a rising edge where `pcode_valid && pcode_ready`.
- Code mapping:
  - 100 → 1000
  - 011 → 0100
  - 010 → 0010
  - 001 → 0001
  - 000 → 0000 (stored; replayed as an idle slot with `x_valid`=1)
- Invalid codes 101, 110, 111:
  - The handshake completes, but the code is not stored.
  - `err`=1 for exactly the following cycle; `count` is unchanged.
- FIFO: circular with wrap-around pointers.
  - Pushes only when `count < DEPTH`, as sampled before the edge.
  - A simultaneous push and pop when full is not possible, because `ready` is already 0.
  - Simultaneous push and pop at any other level leaves `count` unchanged.
- FSM states: IDLE, HOLD.
  - IDLE: if `count != 0`, pop, load `x`, set `x_valid`=1, set `cnt`=HOLD-1, then go to HOLD. Otherwise `x`=0 and `x_valid`=0.
  - HOLD, `cnt != 0`: `cnt`--.
  - HOLD, `cnt == 0` and FIFO non-empty: pop, load the next `x`, set `cnt`=HOLD-1, stay in HOLD. There is no gap cycle between codes.
  - HOLD, `cnt == 0` and FIFO empty: set `x`=0 and `x_valid`=0, then go to IDLE.
- Reset, including mid-operation: immediately and asynchronously sets
  - `x`=0000, `x_valid`=0, `err`=0
  - `count`=0 (queued codes are discarded), pointers=0
  - state=IDLE, `busy`=0
- `pcode_ready` is combinational from `count`, so it reads 1 during and after reset.

## Timing
- All outputs except `pcode_ready` are registered.
- Latency: a code accepted at edge k into an empty, idle block gives `x`/`x_valid` valid after edge k+1.
  - Held for exactly HOLD cycles.
  - Deasserted after edge k+1+HOLD if no further code is queued.
- `err` is asserted after the accepting edge and cleared after the next edge.
- `count` is updated after each edge.
  - `pcode_ready` falls in the cycle after the push that makes `count`=DEPTH.
  - It rises in the cycle after the next pop.
- Sustained throughput is one code per HOLD cycles; `x_valid` stays continuously high while the FIFO is non-empty.

## Test plan
1. Single code: after reset, push 011 at edge k (HOLD=3).
   - `x`=0100 and `x_valid`=1 after edges k+1 through k+3.
   - `x_valid`=0 and `x`=0000 after edge k+4.
   - `busy` falls with `x_valid`.
2. Back-to-back: push 100, 001, 010 on consecutive cycles.
   - `x` shows 1000, 0001, 0010, each for 3 cycles.
   - `x_valid` is high for 9 contiguous cycles; `count` peaks at 2.
3. Full FIFO (DEPTH=4): hold `pcode_valid`=1 with 001 continuously.
   - 5 codes are accepted (1 popped, 4 queued); `pcode_ready`=0 with `count`=4.
   - The 6th code is accepted only in the cycle after the next pop.
   - No code is lost or duplicated; check the total count of one-hot slots.
4. Invalid then valid: push 110, then 001.
   - `err`=1 for one cycle, `count` stays 0, `x_valid` stays 0 for the 110.
   - 001 is then decoded to 0001 normally.
5. Idle code: push 000.
   - `x_valid`=1 with `x`=0000 for 3 cycles.
   - `err`=0.
6. Reset mid-HOLD: queue 3 codes, then pull `rst_n` low during the first code's second hold cycle.
   - `x`, `x_valid`, `count`, and `busy` are 0 immediately.
   - After release, a pushed 100 decodes with the standard latency and the old codes never reappear.
